// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register ids
// and the lifecycle state of the pipeline controller.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;

   localparam logic [3:0] SAOK    = 4'h1;
   localparam logic [3:0] SHLT    = 4'h2;
   localparam logic [3:0] SADR    = 4'h3;
   localparam logic [3:0] SINS    = 4'h4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   function automatic logic is_exc(input logic [3:0] stat);
      return stat != SAOK;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bus between the pipeline datapath and pipe_ctrl: hazard inputs
// from the stage registers, stall/bubble strobes and status back out.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic [3:0]       D_icode;
   logic [3:0]       E_icode;
   logic [3:0]       M_icode;
   logic [3:0]       W_icode;
   logic [3:0]       d_srcA;
   logic [3:0]       d_srcB;
   logic [3:0]       E_dstM;
   logic             e_Cnd;
   logic [3:0]       m_stat;
   logic [3:0]       W_stat;
   logic             F_stall;
   logic             D_stall;
   logic             W_stall;
   logic             D_bubble;
   logic             E_bubble;
   logic             M_bubble;
   logic             set_cc;
   logic [1:0]       state;
   logic [3:0]       cpu_stat;
   logic             halted;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] ret_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bub_cnt;

   modport master (
      output start, D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB,
             E_dstM, e_Cnd, m_stat, W_stat,
      input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
             set_cc, state, cpu_stat, halted, cyc_cnt, ret_cnt, stall_cnt,
             bub_cnt
   );

   modport slave (
      input  start, D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB,
             E_dstM, e_Cnd, m_stat, W_stat,
      output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
             set_cc, state, cpu_stat, halted, cyc_cnt, ret_cnt, stall_cnt,
             bub_cnt
   );
endinterface

// File: rtl/pipe_hazard.sv
// Purely combinational hazard detection: load-use, return, branch
// mispredict and memory/writeback exceptions.
module pipe_hazard
   import y86_pkg::*;
(
   input  logic [3:0] i_D_icode,
   input  logic [3:0] i_E_icode,
   input  logic [3:0] i_M_icode,
   input  logic [3:0] i_d_srcA,
   input  logic [3:0] i_d_srcB,
   input  logic [3:0] i_E_dstM,
   input  logic       i_e_Cnd,
   input  logic [3:0] i_m_stat,
   input  logic [3:0] i_W_stat,
   output logic       o_lu,
   output logic       o_rt,
   output logic       o_mp,
   output logic       o_mx,
   output logic       o_wx
);
   logic w_is_load;

   assign w_is_load = (i_E_icode == IMRMOVQ) || (i_E_icode == IPOPQ);
   assign o_lu = w_is_load && (i_E_dstM != RNONE) &&
                 ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
   assign o_rt = (i_D_icode == IRET) || (i_E_icode == IRET) || (i_M_icode == IRET);
   assign o_mp = (i_E_icode == IJXX) && !i_e_Cnd;
   assign o_mx = is_exc(i_m_stat);
   assign o_wx = is_exc(i_W_stat);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: gates hazard strobes by lifecycle state, runs the
// idle/run/drain/halt FSM and keeps wrapping performance counters.
module pipe_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic       clk,
   input  logic       rst_n,
   pipe_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic w_lu, w_rt, w_mp, w_mx, w_wx;
   logic w_active;
   logic w_f_stall, w_d_stall, w_w_stall;
   logic w_d_bubble, w_e_bubble, w_m_bubble, w_set_cc;

   state_e           r_state;
   logic [3:0]       r_cpu_stat;
   logic             r_halted;
   logic [CNT_W-1:0] r_cyc_cnt, r_ret_cnt, r_stall_cnt, r_bub_cnt;

   pipe_hazard u_hazard (
      .i_D_icode (bus.D_icode),
      .i_E_icode (bus.E_icode),
      .i_M_icode (bus.M_icode),
      .i_d_srcA  (bus.d_srcA),
      .i_d_srcB  (bus.d_srcB),
      .i_E_dstM  (bus.E_dstM),
      .i_e_Cnd   (bus.e_Cnd),
      .i_m_stat  (bus.m_stat),
      .i_W_stat  (bus.W_stat),
      .o_lu      (w_lu),
      .o_rt      (w_rt),
      .o_mp      (w_mp),
      .o_mx      (w_mx),
      .o_wx      (w_wx)
   );

   assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);

   // Outside RUN/DRAIN the whole pipe is frozen with nops in E and M.
   always_comb begin
      w_f_stall  = 1'b1;
      w_d_stall  = 1'b1;
      w_w_stall  = 1'b1;
      w_d_bubble = 1'b0;
      w_e_bubble = 1'b1;
      w_m_bubble = 1'b1;
      w_set_cc   = 1'b0;
      if (w_active) begin
         w_f_stall  = w_lu | w_rt;
         w_d_stall  = w_lu;
         w_d_bubble = w_mp | (!w_lu & w_rt);
         w_e_bubble = w_mp | w_lu;
         w_m_bubble = w_mx | w_wx;
         w_w_stall  = w_wx;
         w_set_cc   = (bus.E_icode == IOPQ) & !w_mx & !w_wx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cpu_stat  <= SAOK;
         r_halted    <= 1'b0;
         r_cyc_cnt   <= '0;
         r_ret_cnt   <= '0;
         r_stall_cnt <= '0;
         r_bub_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) r_state <= ST_RUN;
            ST_RUN, ST_DRAIN: begin
               if (w_wx) begin
                  r_state    <= ST_HALT;
                  r_halted   <= 1'b1;
                  r_cpu_stat <= bus.W_stat;
               end else if (w_mx && r_state == ST_RUN) begin
                  r_state <= ST_DRAIN;
               end
            end
            default: ;
         endcase
         if (w_active) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
            if (bus.W_stat == SAOK && bus.W_icode != INOP)
               r_ret_cnt <= r_ret_cnt + CNT_ONE;
            if (w_f_stall)
               r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_d_bubble || w_e_bubble || w_m_bubble)
               r_bub_cnt <= r_bub_cnt + CNT_ONE;
         end
      end
   end

   assign bus.F_stall   = w_f_stall;
   assign bus.D_stall   = w_d_stall;
   assign bus.W_stall   = w_w_stall;
   assign bus.D_bubble  = w_d_bubble;
   assign bus.E_bubble  = w_e_bubble;
   assign bus.M_bubble  = w_m_bubble;
   assign bus.set_cc    = w_set_cc;
   assign bus.state     = r_state;
   assign bus.cpu_stat  = r_cpu_stat;
   assign bus.halted    = r_halted;
   assign bus.cyc_cnt   = r_cyc_cnt;
   assign bus.ret_cnt   = r_ret_cnt;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.bub_cnt   = r_bub_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard strobes, lifecycle FSM, counters.
module tb_pipe_ctrl;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   pipe_ctrl_if #(.CNT_W(32)) bus ();

   pipe_ctrl #(.CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic defaults();
      bus.start   = 1'b0;
      bus.D_icode = 4'h1;
      bus.E_icode = 4'h1;
      bus.M_icode = 4'h1;
      bus.W_icode = 4'h1;
      bus.d_srcA  = 4'hF;
      bus.d_srcB  = 4'hF;
      bus.E_dstM  = 4'hF;
      bus.e_Cnd   = 1'b0;
      bus.m_stat  = 4'h1;
      bus.W_stat  = 4'h1;
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      next();
      next();
      rst_n = 1'b1;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      next();
      bus.start = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      defaults();

      // Reset state and IDLE outputs
      do_reset();
      #1;
      check("rst_state", bus.state, 0);
      check("rst_cpu_stat", bus.cpu_stat, 1);
      check("rst_halted", bus.halted, 0);
      check("rst_cyc", bus.cyc_cnt, 0);
      check("idle_F_stall", bus.F_stall, 1);
      check("idle_D_stall", bus.D_stall, 1);
      check("idle_W_stall", bus.W_stall, 1);
      check("idle_E_bubble", bus.E_bubble, 1);
      check("idle_M_bubble", bus.M_bubble, 1);
      check("idle_D_bubble", bus.D_bubble, 0);
      bus.E_icode = 4'h6;
      #1 check("idle_set_cc", bus.set_cc, 0);
      bus.E_icode = 4'h1;
      next(); next(); next();
      check("idle_state_hold", bus.state, 0);
      check("idle_cyc", bus.cyc_cnt, 0);
      check("idle_stall_cnt", bus.stall_cnt, 0);
      check("idle_bub_cnt", bus.bub_cnt, 0);

      // Start pulse: IDLE -> RUN, no counting on the start edge
      do_start();
      #1;
      check("start_state", bus.state, 1);
      check("start_cyc", bus.cyc_cnt, 0);
      check("run_F_stall", bus.F_stall, 0);
      check("run_W_stall", bus.W_stall, 0);
      check("run_E_bubble", bus.E_bubble, 0);
      check("run_M_bubble", bus.M_bubble, 0);
      next();

      // Load-use
      bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
      #1;
      check("lu_F_stall", bus.F_stall, 1);
      check("lu_D_stall", bus.D_stall, 1);
      check("lu_E_bubble", bus.E_bubble, 1);
      check("lu_D_bubble", bus.D_bubble, 0);
      next();
      check("lu_cyc", bus.cyc_cnt, 2);
      check("lu_stall_cnt", bus.stall_cnt, 1);
      check("lu_bub_cnt", bus.bub_cnt, 1);

      // Mispredict with ret in D
      defaults();
      bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.D_icode = 4'h9;
      #1;
      check("mprt_F_stall", bus.F_stall, 1);
      check("mprt_D_bubble", bus.D_bubble, 1);
      check("mprt_E_bubble", bus.E_bubble, 1);
      check("mprt_D_stall", bus.D_stall, 0);
      bus.e_Cnd = 1'b1; bus.D_icode = 4'h1;
      #1;
      check("taken_E_bubble", bus.E_bubble, 0);
      bus.e_Cnd = 1'b0; bus.D_icode = 4'h9;
      next();
      check("mprt_stall_cnt", bus.stall_cnt, 2);
      check("mprt_bub_cnt", bus.bub_cnt, 2);

      // OPq sets CC; then load-use together with ret
      defaults();
      bus.E_icode = 4'h6;
      #1 check("opq_set_cc", bus.set_cc, 1);
      bus.m_stat = 4'h3;
      #1 check("opq_mx_set_cc", bus.set_cc, 0);
      bus.m_stat = 4'h1;
      bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcB = 4'h3; bus.D_icode = 4'h9;
      #1;
      check("lurt_D_stall", bus.D_stall, 1);
      check("lurt_D_bubble", bus.D_bubble, 0);
      check("lurt_F_stall", bus.F_stall, 1);
      next();
      check("lurt_cyc", bus.cyc_cnt, 4);
      check("lurt_stall_cnt", bus.stall_cnt, 3);
      check("lurt_bub_cnt", bus.bub_cnt, 3);

      // Memory exception -> DRAIN, then writeback exception -> HALT
      defaults();
      bus.m_stat = 4'h3;
      #1;
      check("mx_M_bubble", bus.M_bubble, 1);
      check("mx_W_stall", bus.W_stall, 0);
      next();
      check("drain_state", bus.state, 2);
      check("drain_halted", bus.halted, 0);
      bus.m_stat = 4'h1; bus.W_stat = 4'h3;
      #1;
      check("wx_W_stall", bus.W_stall, 1);
      check("wx_M_bubble", bus.M_bubble, 1);
      next();
      check("halt_state", bus.state, 3);
      check("halt_cpu_stat", bus.cpu_stat, 3);
      check("halt_halted", bus.halted, 1);
      check("halt_cyc", bus.cyc_cnt, 6);
      check("halt_bub_cnt", bus.bub_cnt, 5);
      bus.W_stat = 4'h1;
      do_start();
      next(); next();
      check("halt_hold_state", bus.state, 3);
      check("halt_hold_cpu_stat", bus.cpu_stat, 3);
      check("halt_hold_W_stall", bus.W_stall, 1);
      check("halt_hold_cyc", bus.cyc_cnt, 6);

      // Simultaneous mx and wx: straight RUN -> HALT
      defaults();
      do_reset();
      #1 check("rst2_state", bus.state, 0);
      next();
      do_start();
      bus.m_stat = 4'h2; bus.W_stat = 4'h2;
      next();
      check("direct_halt_state", bus.state, 3);
      check("direct_halt_cpu_stat", bus.cpu_stat, 2);
      check("direct_halt_halted", bus.halted, 1);

      // Retire counting, then reset mid-run
      defaults();
      do_reset();
      next();
      do_start();
      for (int i = 0; i < 5; i++) begin
         bus.W_icode = (i % 2 == 0) ? 4'h6 : 4'h1;
         next();
      end
      check("ret_cyc", bus.cyc_cnt, 5);
      check("ret_ret_cnt", bus.ret_cnt, 3);
      check("ret_state", bus.state, 1);
      rst_n = 1'b0;
      next();
      rst_n = 1'b1;
      defaults();
      #1;
      check("midrst_state", bus.state, 0);
      check("midrst_cyc", bus.cyc_cnt, 0);
      check("midrst_ret", bus.ret_cnt, 0);
      check("midrst_stall", bus.stall_cnt, 0);
      check("midrst_bub", bus.bub_cnt, 0);
      check("midrst_cpu_stat", bus.cpu_stat, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control unit for the five-stage Y86-64 core. It generates per-stage stall and bubble strobes for the F/D/E/M/W pipeline registers, including the `W_stall` input of the writeback register. It also gates condition-code updates and sequences the processor through an idle → run → drain → halt lifecycle. It keeps wrapping performance counters for cycles, retired instructions, stalls and bubbles.

## Interface
Parameters:
- `CNT_W`, 32, width of each performance counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; leaves IDLE.
- `D_icode`, `E_icode`, `M_icode`, `W_icode`  in  4 each  icodes held in the D/E/M/W registers.
- `d_srcA`, `d_srcB`  in  4 each  decode-stage source registers.
- `E_dstM`  in  4  load destination held in the E register.
- `e_Cnd`  in  1  execute-stage branch condition.
- `m_stat`, `W_stat`  in  4 each  memory-stage status and W-register status.
- `F_stall`, `D_stall`, `W_stall`  out  1 each  hold the register.
- `D_bubble`, `E_bubble`, `M_bubble`  out  1 each  load a nop (icode 1, stat AOK, dst 0xF) into the register.
- `set_cc`  out  1  allow an OPq in execute to write CC.
- `state`  out  2  current lifecycle state.
- `cpu_stat`  out  4  latched final status.
- `halted`  out  1  high in HALT.
- `cyc_cnt`, `ret_cnt`, `stall_cnt`, `bub_cnt`  out  CNT_W each  performance counters.

## Operation
- Encodings: IHALT=0, INOP=1, IJXX=7, IOPQ=6, IMRMOVQ=5, IRET=9, IPOPQ=B, RNONE=F; SAOK=1, SHLT=2, SADR=3, SINS=4. An "exception" is any stat other than SAOK.
- Hazard terms, evaluated combinationally:
  - `lu` (load-use) = E_icode∈{MRMOVQ,POPQ} && E_dstM≠RNONE && E_dstM∈{d_srcA,d_srcB}.
  - `rt` (return) = IRET∈{D_icode,E_icode,M_icode}.
  - `mp` (mispredict) = E_icode==IJXX && !e_Cnd.
  - `mx` = m_stat is an exception.
  - `wx` = W_stat is an exception.
- RUN and DRAIN outputs:
  - F_stall = lu|rt.
  - D_stall = lu.
  - D_bubble = mp | (!lu & rt).
  - E_bubble = mp|lu.
  - M_bubble = mx|wx.
  - W_stall = wx.
  - set_cc = E_icode==IOPQ & !mx & !wx.
- IDLE and HALT outputs:
  - F_stall = D_stall = W_stall = 1.
  - E_bubble = M_bubble = 1.
  - D_bubble = 0.
  - set_cc = 0.
- States: IDLE=0, RUN=1, DRAIN=2, HALT=3.
  - IDLE→RUN on `start`.
  - RUN→DRAIN when mx and !wx.
  - RUN→HALT when wx; this takes priority over RUN→DRAIN.
  - DRAIN→HALT when wx.
  - HALT has no exit except reset.
  - `start` is ignored outside IDLE.
- cpu_stat loads W_stat on the entry edge into HALT and holds it afterwards.
- Counters wrap modulo 2^CNT_W and count only in RUN or DRAIN:
  - cyc_cnt increments every cycle.
  - ret_cnt increments when W_stat==SAOK and W_icode≠INOP.
  - stall_cnt increments when F_stall.
  - bub_cnt increments when any of D_bubble, E_bubble or M_bubble is asserted.

## Timing
- Reset (rst_n low at an edge) gives:
  - state=IDLE.
  - cpu_stat=SAOK.
  - halted=0.
  - all counters 0.
  - Stall/bubble outputs follow their IDLE values in the same cycle.
- Reset asserted mid-run aborts to IDLE on that edge. No drain is performed and counters are cleared.
- All stall/bubble and set_cc outputs are combinational from the inputs and the current state, with zero-cycle latency. Pipeline registers sample them at the same edge.
- State, cpu_stat, halted and counters update on the edge after their condition. halted rises one cycle after wx is first seen in RUN or DRAIN.
- A stage never has stall and bubble asserted together. Under lu & rt, D_stall wins and D_bubble=0.
- mp & rt together (jxx in E, ret in D): F_stall=1, D_bubble=1, E_bubble=1.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants.
  - stat constants and an `is_exc` function.
  - RNONE.
  - lifecycle state encoding.
  - It is shared with the existing pipeline stages.
- Sub-module `pipe_hazard`: the purely combinational lu/rt/mp/mx/wx detection. pipe_ctrl adds state gating, the FSM and the counters.

## Test plan
- Reset then `start` pulse → state 0→1. While in IDLE, F_stall=D_stall=W_stall=1 and all counters stay 0.
- E_icode=5, E_dstM=3, d_srcA=3 in RUN → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. stall_cnt and bub_cnt each increase by 1.
- E_icode=7, e_Cnd=0, D_icode=9 → F_stall=1, D_bubble=1, E_bubble=1, D_stall=0.
- m_stat=3 in RUN, then W_stat=3 one cycle later → DRAIN. Next edge gives HALT, cpu_stat=3, halted=1. W_stall stays 1 indefinitely.
- Both m_stat=2 and W_stat=2 in the same RUN cycle → direct RUN→HALT; DRAIN is never entered.
- Five cycles of RUN, of which 3 have W_icode=6 and W_stat=1, then rst_n=0 for one edge → before reset cyc_cnt=5 and ret_cnt=3. After reset all counters are 0 and state=IDLE.
